// File: rtl/bounded_updown_counter_pkg.sv
// Shared constants for the bounded up/down counter: mode encodings and
// the encodings of the up_down control.
package bounded_updown_counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/bounded_updown_counter_tick_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle tick on the last
// cycle of each group; clear restarts the group from zero.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   // A one-bit phase register is kept even when PRESCALE is 1; it simply stays at 0.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] phase;

   assign tick = enable && (phase == PW'(PRESCALE - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= '0;
      end else if (clear || tick) begin
         phase <= '0;
      end else if (enable) begin
         phase <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/bounded_updown_counter.sv
// Up/down counter with programmable inclusive bounds, wrap or saturate
// behaviour at the limits, clamped loads and a prescaled count tick.
module bounded_updown_counter
   import bounded_updown_counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int STEP_W   = 4,
   parameter int PRESCALE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              up_down,
   input  logic              mode,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  min_val,
   input  logic [WIDTH-1:0]  max_val,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_data,
   output logic [WIDTH-1:0]  count,
   output logic              at_min,
   output logic              at_max,
   output logic              tc,
   output logic              cfg_err
);

   // Two guard bits: one for carry past the top, one for sign below zero.
   localparam int CW = WIDTH + 2;

   logic                 tick;
   logic signed [CW-1:0] count_s;
   logic signed [CW-1:0] step_s;
   logic signed [CW-1:0] min_s;
   logic signed [CW-1:0] max_s;
   logic signed [CW-1:0] cand;
   logic [WIDTH-1:0]     count_next;
   logic                 tc_next;

   tick_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .clear  (load),
      .tick   (tick)
   );

   assign at_min  = (count == min_val);
   assign at_max  = (count == max_val);
   assign cfg_err = (min_val > max_val);

   always_comb begin
      count_s    = signed'({2'b00, count});
      step_s     = signed'({{(CW - STEP_W){1'b0}}, step});
      min_s      = signed'({2'b00, min_val});
      max_s      = signed'({2'b00, max_val});
      cand       = (up_down == DIR_UP) ? (count_s + step_s) : (count_s - step_s);
      count_next = count;
      tc_next    = 1'b0;

      if (load) begin
         if (!cfg_err) begin
            if (load_data > max_val) begin
               count_next = max_val;
            end else if (load_data < min_val) begin
               count_next = min_val;
            end else begin
               count_next = load_data;
            end
         end
      end else if (tick && !cfg_err) begin
         // An out-of-range count (bounds moved under it) is pulled back silently first.
         if (count > max_val) begin
            count_next = max_val;
         end else if (count < min_val) begin
            count_next = min_val;
         end else if (step != '0) begin
            if ((up_down == DIR_UP) && (cand > max_s)) begin
               count_next = (mode == MODE_WRAP) ? min_val : max_val;
               tc_next    = 1'b1;
            end else if ((up_down == DIR_DOWN) && (cand < min_s)) begin
               count_next = (mode == MODE_WRAP) ? max_val : min_val;
               tc_next    = 1'b1;
            end else begin
               count_next = cand[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= count_next;
         tc    <= tc_next;
      end
   end

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Directed bench for bounded_updown_counter with PRESCALE=4; every expected
// value below is hand-computed from the counter's defined behaviour.
module tb_bounded_updown_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       up_down;
   logic       mode;
   logic [3:0] step;
   logic [7:0] min_val;
   logic [7:0] max_val;
   logic       load;
   logic [7:0] load_data;
   logic [7:0] count;
   logic       at_min;
   logic       at_max;
   logic       tc;
   logic       cfg_err;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   bounded_updown_counter #(
      .WIDTH    (8),
      .STEP_W   (4),
      .PRESCALE (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .up_down   (up_down),
      .mode      (mode),
      .step      (step),
      .min_val   (min_val),
      .max_val   (max_val),
      .load      (load),
      .load_data (load_data),
      .count     (count),
      .at_min    (at_min),
      .at_max    (at_max),
      .tc        (tc),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
         $display("check %-14s observed=%0d expected=%0d ok", tag, obs, exp);
      end else begin
         fails++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Four enabled cycles from prescaler phase 0: three quiet ones, then the tick.
   task automatic do_tick(input string tag, input logic [7:0] prev,
                          input logic [7:0] exp, input logic exp_tc);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check({tag, "_hold"}, 32'(count), 32'(prev));
         check({tag, "_hold_tc"}, 32'(tc), 32'd0);
      end
      cyc();
      check(tag, 32'(count), 32'(exp));
      check({tag, "_tc"}, 32'(tc), 32'(exp_tc));
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      up_down   = 1'b1;
      mode      = 1'b0;
      step      = 4'd3;
      min_val   = 8'd10;
      max_val   = 8'd20;
      load      = 1'b0;
      load_data = 8'd0;
      cyc();
      cyc();
      check("rst_count", 32'(count), 32'd0);
      check("rst_tc", 32'(tc), 32'd0);
      check("rst_at_min", 32'(at_min), 32'd0);
      check("rst_cfg_err", 32'(cfg_err), 32'd0);
      rst = 1'b0;

      // Wrap upward: 10 -> 13 -> 16 -> 19 -> 10
      load = 1'b1; load_data = 8'd10;
      cyc();
      check("load10", 32'(count), 32'd10);
      check("load10_at_min", 32'(at_min), 32'd1);
      load = 1'b0; enable = 1'b1;
      do_tick("wrap13", 8'd10, 8'd13, 1'b0);
      do_tick("wrap16", 8'd13, 8'd16, 1'b0);
      do_tick("wrap19", 8'd16, 8'd19, 1'b0);
      do_tick("wrap10", 8'd19, 8'd10, 1'b1);
      cyc();
      check("wrap_tc_drop", 32'(tc), 32'd0);

      // Saturate downward from 12
      enable = 1'b0; mode = 1'b1; up_down = 1'b0;
      load = 1'b1; load_data = 8'd12;
      cyc();
      check("load12", 32'(count), 32'd12);
      load = 1'b0; enable = 1'b1;
      do_tick("sat_dn1", 8'd12, 8'd10, 1'b1);
      do_tick("sat_dn2", 8'd10, 8'd10, 1'b1);
      do_tick("sat_dn3", 8'd10, 8'd10, 1'b1);
      check("sat_at_min", 32'(at_min), 32'd1);

      // Prescale with enable gap
      enable = 1'b0; step = 4'd1; up_down = 1'b1; mode = 1'b0;
      load = 1'b1; load_data = 8'd10;
      cyc();
      load = 1'b0; enable = 1'b1;
      do_tick("pre11", 8'd10, 8'd11, 1'b0);
      cyc();
      cyc();
      check("pre_partial", 32'(count), 32'd11);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      check("pre_gap_hold", 32'(count), 32'd11);
      enable = 1'b1;
      cyc();
      check("pre_resume3", 32'(count), 32'd11);
      cyc();
      check("pre_resume4", 32'(count), 32'd12);

      // Load beats a simultaneous tick and clears the prescaler
      step = 4'd3; mode = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      check("pre_phase3", 32'(count), 32'd12);
      load = 1'b1; load_data = 8'd200;
      cyc();
      check("load200", 32'(count), 32'd20);
      check("load200_tc", 32'(tc), 32'd0);
      check("load200_at_max", 32'(at_max), 32'd1);
      load = 1'b0;
      do_tick("sat_up", 8'd20, 8'd20, 1'b1);
      enable = 1'b0; load = 1'b1; load_data = 8'd3;
      cyc();
      check("load3_clamp", 32'(count), 32'd10);
      load = 1'b0;

      // Inverted bounds freeze the count
      min_val = 8'd30; max_val = 8'd5;
      #1;
      check("cfg_err_set", 32'(cfg_err), 32'd1);
      load = 1'b1; load_data = 8'd25;
      cyc();
      check("cfg_load", 32'(count), 32'd10);
      load = 1'b0; enable = 1'b1;
      do_tick("cfg_tick", 8'd10, 8'd10, 1'b0);
      min_val = 8'd10; max_val = 8'd20; mode = 1'b0;
      #1;
      check("cfg_err_clr", 32'(cfg_err), 32'd0);
      do_tick("cfg_resume", 8'd10, 8'd13, 1'b0);

      // Bound moved above the count, step 0, then wrap downward
      min_val = 8'd15;
      do_tick("clamp_min", 8'd13, 8'd15, 1'b0);
      check("clamp_at_min", 32'(at_min), 32'd1);
      step = 4'd0;
      do_tick("step0", 8'd15, 8'd15, 1'b0);
      step = 4'd3; up_down = 1'b0;
      do_tick("wrap_dn", 8'd15, 8'd20, 1'b1);

      // Asynchronous reset mid-prescale
      min_val = 8'd0; step = 4'd1; up_down = 1'b1;
      cyc();
      cyc();
      #3;
      rst = 1'b1;
      #1;
      check("async_rst", 32'(count), 32'd0);
      check("async_rst_tc", 32'(tc), 32'd0);
      check("async_at_min", 32'(at_min), 32'd1);
      cyc();
      rst = 1'b0;
      do_tick("post_rst", 8'd0, 8'd1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
